valid_stream_to_handshake_fifo: RTL and testbench

Receiving end of the team's valid-only push stream (data plus valid, no backpressure). Buffers incoming words in a FIFO and re-presents them on a ready/valid handshake output, so a downstream consumer can stall. Words that arrive while the buffer is full are dropped. Each drop is reported through a sticky overflow flag and a saturating drop counter. Sits at every boundary where a free-running producer feeds a stalling consumer.

---
 rtl/stream_fifo_pkg.sv | 14 +
 rtl/valid_stream_to_handshake_fifo_if.sv | 23 ++
 rtl/valid_stream_to_handshake_fifo_sdp_ram_reg.sv | 37 +++
 rtl/valid_stream_to_handshake_fifo.sv | 120 ++++++++++++
 tb/tb_valid_stream_to_handshake_fifo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the valid-stream to handshake FIFO.
//   cnt_width(n) : bits needed for an occupancy of 0..n+1 (storage plus output register)
//   ptr_width(n) : bits needed to address n storage words
package stream_fifo_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/valid_stream_to_handshake_fifo_if.sv
// Bundle of the push stream (data + valid, no backpressure) and the
// ready/valid pop handshake.
//   master : environment side (drives push data/valid and out_ready)
//   slave  : FIFO side (drives out_data/out_valid)
interface valid_stream_to_handshake_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_in_data;
  logic             i_in_valid;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             i_out_ready;

  modport master (
    output i_in_data, i_in_valid, i_out_ready,
    input  o_out_data, o_out_valid
  );

  modport slave (
    input  i_in_data, i_in_valid, i_out_ready,
    output o_out_data, o_out_valid
  );
endinterface

// File: rtl/valid_stream_to_handshake_fifo_sdp_ram_reg.sv
// Simple dual-port RAM with a registered read port.
//   i_clock, i_reset      : clock, synchronous active-high reset (rdata only)
//   i_we, i_waddr, i_wdata: write port
//   i_re, i_raddr         : read enable / address
//   o_rdata               : registered read data, holds when i_re is low
module sdp_ram_reg
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 1024
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_we,
  input  logic [ptr_width(NUM_WORDS)-1:0] i_waddr,
  input  logic [WIDTH-1:0]                i_wdata,
  input  logic                            i_re,
  input  logic [ptr_width(NUM_WORDS)-1:0] i_raddr,
  output logic [WIDTH-1:0]                o_rdata
);

  logic [WIDTH-1:0] mem [NUM_WORDS];
  logic [WIDTH-1:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge i_clock) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)   rdata_q <= '0;
    else if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/valid_stream_to_handshake_fifo.sv
// Converts a free-running valid-only push stream into a ready/valid output.
// Words arriving while storage is full are dropped and reported.
//   i_clock, i_reset : clock, synchronous active-high reset
//   s_if             : push stream in, handshake out (slave modport)
//   o_count          : words in storage plus the output register
//   o_full           : storage holds NUM_WORDS words
//   o_overflow       : sticky, a word has been dropped
//   i_clear_overflow : clears o_overflow and o_drop_count
//   o_drop_count     : saturating count of dropped words
module valid_stream_to_handshake_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_WORDS      = 1024,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  valid_stream_to_handshake_fifo_if.slave s_if,
  output logic [cnt_width(NUM_WORDS)-1:0] o_count,
  output logic                            o_full,
  output logic                            o_overflow,
  input  logic                            i_clear_overflow,
  output logic [DROP_CNT_WIDTH-1:0]       o_drop_count
);

  localparam int PW = ptr_width(NUM_WORDS);
  localparam int CW = cnt_width(NUM_WORDS);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_WORDS);

  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_depth
    $error("NUM_WORDS must be a power of two and at least 2");
  end

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             scount_q, scount_d, count_q, count_d;
  logic                      out_valid_q, out_valid_d;
  logic                      full_q, full_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      push, drop, load;

  always_comb begin
    // Full decision uses start-of-cycle occupancy only, so a same-cycle
    // load never frees a slot for the incoming word.
    push = s_if.i_in_valid && (scount_q != FULL_CNT);
    drop = s_if.i_in_valid && (scount_q == FULL_CNT);
    load = (scount_q != '0) && (!out_valid_q || s_if.i_out_ready);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + PW'(1) : rd_ptr_q;

    scount_d = scount_q;
    if (push && !load)      scount_d = scount_q + CW'(1);
    else if (!push && load) scount_d = scount_q - CW'(1);

    out_valid_d = out_valid_q;
    if (load)                                  out_valid_d = 1'b1;
    else if (out_valid_q && s_if.i_out_ready)  out_valid_d = 1'b0;

    count_d = scount_d + CW'(out_valid_d);
    full_d  = (scount_d == FULL_CNT);

    // A drop coinciding with a clear restarts the tally at one.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (i_clear_overflow)     drop_cnt_d = DROP_CNT_WIDTH'(1);
      else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end else if (i_clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      scount_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scount_q    <= scount_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // The RAM read register doubles as the output data register.
  sdp_ram_reg #(
    .WIDTH    (WIDTH),
    .NUM_WORDS(NUM_WORDS)
  ) u_ram (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_we   (push && !i_reset),
    .i_waddr(wr_ptr_q),
    .i_wdata(s_if.i_in_data),
    .i_re   (load && !i_reset),
    .i_raddr(rd_ptr_q),
    .o_rdata(s_if.o_out_data)
  );

  assign s_if.o_out_valid = out_valid_q;
  assign o_count          = count_q;
  assign o_full           = full_q;
  assign o_overflow       = overflow_q;
  assign o_drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_valid_stream_to_handshake_fifo.sv
module tb_valid_stream_to_handshake_fifo;
  import stream_fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int NW    = 4;
  localparam int DCW   = 2;
  localparam int DMAX  = (1 << DCW) - 1;
  localparam int CW    = cnt_width(NW);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clr = 1'b0;
  logic [CW-1:0]  o_count;
  logic           o_full, o_overflow;
  logic [DCW-1:0] o_drop_count;

  valid_stream_to_handshake_fifo_if #(.WIDTH(WIDTH)) fifo_if ();

  valid_stream_to_handshake_fifo #(
    .WIDTH(WIDTH), .NUM_WORDS(NW), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .s_if(fifo_if),
    .o_count(o_count), .o_full(o_full), .o_overflow(o_overflow),
    .i_clear_overflow(clr), .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: queue of stored words plus output register
  int mq[$];
  bit m_valid;
  int m_data, m_drop;
  bit m_ov;

  int got[$];
  bit rec_en;
  int max_cnt;

  task automatic check(string tag, logic [31:0] got_v, logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_update();
    int depth;
    bit ld, dropped;
    if (rst) begin
      mq.delete();
      m_valid = 0; m_data = 0; m_ov = 0; m_drop = 0;
    end else begin
      depth   = mq.size();
      ld      = (depth != 0) && (!m_valid || fifo_if.i_out_ready);
      dropped = fifo_if.i_in_valid && (depth == NW);
      if (ld) begin
        m_data  = mq.pop_front();
        m_valid = 1;
      end else if (m_valid && fifo_if.i_out_ready) begin
        m_valid = 0;
      end
      if (fifo_if.i_in_valid && !dropped) mq.push_back(int'(fifo_if.i_in_data));
      if (dropped) begin
        m_ov   = 1;
        m_drop = clr ? 1 : ((m_drop == DMAX) ? DMAX : m_drop + 1);
      end else if (clr) begin
        m_ov   = 0;
        m_drop = 0;
      end
    end
  endtask

  task automatic step();
    if (rec_en && !rst && fifo_if.o_out_valid && fifo_if.i_out_ready)
      got.push_back(int'(fifo_if.o_out_data));
    @(posedge clk);
    model_update();
    #1;
    check("out_valid", 32'(fifo_if.o_out_valid), 32'(m_valid));
    check("out_data",  32'(fifo_if.o_out_data),  32'(m_data));
    check("count",     32'(o_count),             32'(mq.size() + int'(m_valid)));
    check("full",      32'(o_full),              32'(mq.size() == NW));
    check("overflow",  32'(o_overflow),          32'(m_ov));
    check("drop_cnt",  32'(o_drop_count),        32'(m_drop));
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
  endtask

  task automatic drive(bit v, int d, bit rdy, bit c, bit r);
    fifo_if.i_in_valid  = v;
    fifo_if.i_in_data   = WIDTH'(d);
    fifo_if.i_out_ready = rdy;
    clr = c;
    rst = r;
  endtask

  initial begin
    int sent[$];
    rec_en = 0;
    max_cnt = 0;
    drive(0, 0, 0, 0, 1);
    step(); step();
    drive(0, 0, 0, 0, 0);
    step();

    // single push, fixed two-cycle latency
    drive(1, 'hA5, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0);
    check("lat_c1_valid", 32'(fifo_if.o_out_valid), 0);
    step();
    check("lat_c2_valid", 32'(fifo_if.o_out_valid), 1);
    check("lat_c2_data",  32'(fifo_if.o_out_data), 'hA5);
    step();
    check("lat_c3_count", 32'(o_count), 0);
    check("lat_c3_valid", 32'(fifo_if.o_out_valid), 0);

    // stalled consumer, fill, drop, drain
    for (int i = 1; i <= 5; i++) begin drive(1, i, 0, 0, 0); step(); end
    check("stall_count", 32'(o_count), 5);
    check("stall_full",  32'(o_full), 1);
    check("stall_head",  32'(fifo_if.o_out_data), 1);
    drive(1, 6, 0, 0, 0); step();
    check("stall_ovf",  32'(o_overflow), 1);
    check("stall_drop", 32'(o_drop_count), 1);
    got.delete(); rec_en = 1;
    for (int i = 0; i < 7; i++) begin drive(0, 0, 1, 0, 0); step(); end
    rec_en = 0;
    check("drain_len", 32'(got.size()), 5);
    for (int i = 0; i < got.size() && i < 5; i++) check("drain_word", 32'(got[i]), 32'(i + 1));

    // full plus simultaneous load: drop still happens
    drive(0, 0, 0, 1, 0); step();
    for (int i = 0; i < 5; i++) begin drive(1, 'h10 + i, 0, 0, 0); step(); end
    drive(1, 'h77, 1, 0, 0); step();
    check("fullpop_drop",  32'(o_drop_count), 1);
    check("fullpop_count", 32'(o_count), 4);
    check("fullpop_full",  32'(o_full), 0);
    drive(1, 'h78, 0, 0, 0); step();
    check("refill_full", 32'(o_full), 1);
    drive(1, 'h79, 0, 1, 0); step();
    check("clr_vs_drop_ovf", 32'(o_overflow), 1);
    check("clr_vs_drop_cnt", 32'(o_drop_count), 1);

    // saturation
    for (int i = 0; i < 5; i++) begin drive(1, 'h80 + i, 0, 0, 0); step(); end
    check("sat_drop", 32'(o_drop_count), DMAX);

    // reset mid-operation, inputs active but ignored
    drive(1, 'hEE, 1, 0, 1); step();
    check("rst_valid", 32'(fifo_if.o_out_valid), 0);
    check("rst_data",  32'(fifo_if.o_out_data), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_drop",  32'(o_drop_count), 0);
    drive(1, 'h3C, 1, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    check("post_rst_valid", 32'(fifo_if.o_out_valid), 1);
    check("post_rst_data",  32'(fifo_if.o_out_data), 'h3C);
    step(); step();

    // wrap-around with toggling ready
    got.delete(); sent.delete(); rec_en = 1; max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) sent.push_back((i * 13 + 7) & 'hFF);
      drive(i % 2 == 0, (i * 13 + 7) & 'hFF, i % 2 == 0, 0, 0);
      step();
    end
    for (int i = 0; i < 6; i++) begin drive(0, 0, 1, 0, 0); step(); end
    rec_en = 0;
    check("wrap_len", 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < got.size() && i < sent.size(); i++) check("wrap_word", 32'(got[i]), 32'(sent[i]));
    check("wrap_max_le3", 32'(max_cnt <= 3), 1);
    check("wrap_nodrop", 32'(o_drop_count), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 255) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
